// File: rtl/instr_issue_if.sv
// Instruction-source handshake bundle for instr_issue_ctrl.
// master = instruction source (fetch / bench), slave = issue controller.
interface instr_issue_if #(
  parameter int DATA_W = 16
);
  logic              InstrValid;
  logic [DATA_W-1:0] Instr;
  logic              InstrReady;

  modport master (output InstrValid, output Instr, input InstrReady);
  modport slave  (input InstrValid, input Instr, output InstrReady);
endinterface

// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl: decodes 16-bit CR16-style instruction words into
// RegFile_Alu controls and sequences them through IDLE->DECODE->EXEC->WB.
// The decoded field registers double as the instruction register, so the
// fields are valid the cycle after the handshake and are held until the
// next legal instruction is loaded.
// Optional feature: define INSTR_SKID_EN for a 1-entry skid buffer that lets
// a word be accepted while busy (1 instruction per 3 cycles).
module instr_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  instr_issue_if.slave          instr_bus,
  input  logic [4:0]            Flags,
  output logic [REG_ADDR_W-1:0] RdestRegLoc,
  output logic [REG_ADDR_W-1:0] RsrcRegLoc,
  output logic [4:0]            OpCode,
  output logic [DATA_W-1:0]     Imm,
  output logic                  Imm_s,
  output logic                  En,
  output logic [4:0]            FlagsQ,
  output logic                  Busy,
  output logic                  IllegalOp
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic                  legal;
    logic [REG_ADDR_W-1:0] rdest;
    logic [REG_ADDR_W-1:0] rsrc;
    logic [4:0]            opcode;
    logic [DATA_W-1:0]     imm;
    logic                  imm_s;
  } dec_t;

  localparam logic [3:0] C_AND = 4'b0001;
  localparam logic [3:0] C_OR  = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_ADD = 4'b0101;
  localparam logic [3:0] C_SUB = 4'b1001;
  localparam logic [3:0] C_CMP = 4'b1011;
  localparam logic [3:0] C_MOV = 4'b1101;
  localparam logic [3:0] C_LUI = 4'b1111;

  state_t                state_q;
  logic [REG_ADDR_W-1:0] rdest_q, rsrc_q;
  logic [4:0]            opcode_q;
  logic [DATA_W-1:0]     imm_q;
  logic                  imm_s_q, en_q, illegal_q;
  logic [4:0]            flags_q;

  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_word;
  logic [7:0]        imm8;
  dec_t              dec;

  assign accept = instr_bus.InstrValid & instr_bus.InstrReady;

`ifdef INSTR_SKID_EN
  logic              skid_full_q;
  logic [DATA_W-1:0] skid_q;

  assign instr_bus.InstrReady = Rst & ~skid_full_q;

  // Choose the word entering the decode registers: a buffered word has
  // priority, otherwise a word accepted directly in IDLE.
  always_comb begin
    load      = 1'b0;
    load_word = instr_bus.Instr;
    if (skid_full_q && (state_q == S_IDLE || state_q == S_WB)) begin
      load      = 1'b1;
      load_word = skid_q;
    end else if (accept && state_q == S_IDLE) begin
      load      = 1'b1;
    end
  end

  // Skid occupancy: set when a word arrives while busy, cleared when consumed.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      skid_full_q <= 1'b0;
    end else if (load && skid_full_q) begin
      skid_full_q <= 1'b0;
    end else if (accept && state_q != S_IDLE) begin
      skid_full_q <= 1'b1;
    end
  end

  // Skid payload.
  // NOTE: data storage needs no reset; it is only read while skid_full_q is set.
  always_ff @(posedge Clk) begin
    if (accept && state_q != S_IDLE) skid_q <= instr_bus.Instr;
  end
`else
  assign instr_bus.InstrReady = Rst & (state_q == S_IDLE);
  assign load                 = accept;
  assign load_word            = instr_bus.Instr;
`endif

  assign imm8 = load_word[7:0];

  // Field decode of the word being loaded.
  // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec       = '0;
    dec.rdest = load_word[11:8];
    if (load_word[15:12] == 4'b0000) begin
      dec.rsrc   = load_word[3:0];
      dec.opcode = {1'b0, load_word[7:4]};
      case (load_word[7:4])
        C_ADD, C_SUB, C_CMP, C_AND, C_OR, C_XOR, C_MOV: dec.legal = 1'b1;
        default:                                        dec.legal = 1'b0;
      endcase
    end else begin
      dec.imm_s  = 1'b1;
      dec.opcode = {1'b0, load_word[15:12]};
      case (load_word[15:12])
        C_ADD, C_SUB, C_CMP: begin
          dec.legal = 1'b1;
          dec.imm   = {{(DATA_W-8){imm8[7]}}, imm8};
        end
        C_AND, C_OR, C_XOR, C_MOV: begin
          dec.legal = 1'b1;
          dec.imm   = {{(DATA_W-8){1'b0}}, imm8};
        end
        C_LUI: begin
          dec.legal  = 1'b1;
          dec.imm    = {imm8, {(DATA_W-8){1'b0}}};
          dec.opcode = {1'b0, C_MOV};
        end
        default: dec.legal = 1'b0;
      endcase
    end
  end

  // Issue FSM with registered outputs; illegal words leave the fields untouched.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      rdest_q   <= '0;
      rsrc_q    <= '0;
      opcode_q  <= '0;
      imm_q     <= '0;
      imm_s_q   <= 1'b0;
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE:   if (load) state_q <= S_DECODE;
        S_DECODE: state_q <= illegal_q ? S_IDLE : S_EXEC;
        S_EXEC: begin
          state_q <= S_WB;
          en_q    <= (opcode_q != {1'b0, C_CMP});
        end
        S_WB: begin
          flags_q <= Flags;
          state_q <= load ? S_DECODE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (load) begin
        illegal_q <= ~dec.legal;
        if (dec.legal) begin
          rdest_q  <= dec.rdest;
          rsrc_q   <= dec.rsrc;
          opcode_q <= dec.opcode;
          imm_q    <= dec.imm;
          imm_s_q  <= dec.imm_s;
        end
      end
    end
  end

  assign RdestRegLoc = rdest_q;
  assign RsrcRegLoc  = rsrc_q;
  assign OpCode      = opcode_q;
  assign Imm         = imm_q;
  assign Imm_s       = imm_s_q;
  assign En          = en_q;
  assign FlagsQ      = flags_q;
  assign IllegalOp   = illegal_q;
  assign Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl: directed vector table, reset
// corner sequences, randomized words against a mnemonic-level model, and
// (with INSTR_SKID_EN) a back-to-back skid sequence.
module tb_instr_issue_ctrl;

`ifdef INSTR_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic        illegal;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [4:0]  opcode;
    logic [15:0] imm;
    logic        imm_s;
    logic        en;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [4:0]  flags;
    exp_t        e;
  } vec_t;

  logic        Clk, Rst;
  logic [4:0]  Flags;
  logic [3:0]  RdestRegLoc, RsrcRegLoc;
  logic [4:0]  OpCode, FlagsQ;
  logic [15:0] Imm;
  logic        Imm_s, En, Busy, IllegalOp;

  int   checks   = 0;
  int   failures = 0;
  exp_t last_legal = '0;
  vec_t vq[$];

  instr_issue_if #(.DATA_W(16)) ibus ();

  instr_issue_ctrl #(.DATA_W(16), .REG_ADDR_W(4)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .instr_bus   (ibus),
    .Flags       (Flags),
    .RdestRegLoc (RdestRegLoc),
    .RsrcRegLoc  (RsrcRegLoc),
    .OpCode      (OpCode),
    .Imm         (Imm),
    .Imm_s       (Imm_s),
    .En          (En),
    .FlagsQ      (FlagsQ),
    .Busy        (Busy),
    .IllegalOp   (IllegalOp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic exp_t mk(input bit il, input int rd, input int rs, input int op,
                              input int imm, input bit s, input bit en);
    exp_t e;
    e.illegal = il;
    e.rdest   = rd[3:0];
    e.rsrc    = rs[3:0];
    e.opcode  = op[4:0];
    e.imm     = imm[15:0];
    e.imm_s   = s;
    e.en      = en;
    return e;
  endfunction

  // Reference: names the instruction, then derives fields with plain arithmetic.
  function automatic exp_t ref_model(input logic [15:0] w);
    exp_t  e;
    int    op, code, imm8, simm;
    bit    imm_form;
    string mn;
    op       = int'(w[15:12]);
    imm_form = (op != 0);
    code     = imm_form ? op : int'(w[7:4]);
    imm8     = int'(w[7:0]);
    case (code)
      5:       mn = "ADD";
      9:       mn = "SUB";
      11:      mn = "CMP";
      1:       mn = "AND";
      2:       mn = "OR";
      3:       mn = "XOR";
      13:      mn = "MOV";
      15:      mn = imm_form ? "LUI" : "";
      default: mn = "";
    endcase
    if (mn == "") begin
      e         = last_legal;
      e.illegal = 1'b1;
      e.en      = 1'b0;
      return e;
    end
    if (!imm_form)                              simm = 0;
    else if (mn == "ADD" || mn == "SUB" || mn == "CMP") simm = (imm8 >= 128) ? imm8 - 256 : imm8;
    else if (mn == "LUI")                       simm = imm8 * 256;
    else                                        simm = imm8;
    e.illegal = 1'b0;
    e.rdest   = w[11:8];
    e.rsrc    = imm_form ? 4'h0 : w[3:0];
    e.imm_s   = imm_form;
    e.imm     = simm[15:0];
    e.opcode  = (mn == "LUI") ? 5'd13 : code[4:0];
    e.en      = (mn != "CMP");
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ":rdest"},  RdestRegLoc, e.rdest);
    check({tag, ":rsrc"},   RsrcRegLoc,  e.rsrc);
    check({tag, ":opcode"}, OpCode,      e.opcode);
    check({tag, ":imm"},    Imm,         e.imm);
    check({tag, ":imm_s"},  Imm_s,       e.imm_s);
  endtask

  // One full instruction from IDLE, checked cycle by cycle.
  task automatic run_instr(input logic [15:0] w, input logic [4:0] f, input exp_t e, input string tag);
    check({tag, ":ready_idle"}, ibus.InstrReady, 1);
    ibus.InstrValid = 1'b1;
    ibus.Instr      = w;
    step();                                   // DECODE
    ibus.InstrValid = 1'b0;
    ibus.Instr      = 16'($urandom);
    Flags           = 5'($urandom);
    check({tag, ":busy_dec"},  Busy, 1);
    check({tag, ":ill_dec"},   IllegalOp, e.illegal);
    check({tag, ":en_dec"},    En, 0);
    check({tag, ":ready_dec"}, ibus.InstrReady, SKID);
    check_fields(tag, e);
    if (e.illegal) begin
      step();                                 // back in IDLE
      check({tag, ":busy_ill"}, Busy, 0);
      check({tag, ":ill_off"},  IllegalOp, 0);
      check({tag, ":en_ill"},   En, 0);
      return;
    end
    last_legal = e;
    step();                                   // EXEC
    check({tag, ":en_exec"},  En, 0);
    check({tag, ":ill_exec"}, IllegalOp, 0);
    step();                                   // WB
    Flags = f;
    check({tag, ":en_wb"},     En, e.en);
    check({tag, ":busy_wb"},   Busy, 1);
    check({tag, ":opcode_wb"}, OpCode, e.opcode);
    step();                                   // IDLE
    check({tag, ":en_after"},  En, 0);
    check({tag, ":busy_end"},  Busy, 0);
    check({tag, ":flagsq"},    FlagsQ, f);
    check({tag, ":imm_hold"},  Imm, e.imm);
  endtask

  // Assert reset in EXEC (phase 2) or WB (phase 3) of an ADDI.
  task automatic reset_mid(input int phase, input string tag);
    ibus.InstrValid = 1'b1;
    ibus.Instr      = 16'h53FE;
    step();
    ibus.InstrValid = 1'b0;
    for (int k = 1; k < phase; k++) step();
    if (phase == 3) check({tag, ":en_before"}, En, 1);
    Rst = 1'b0;
    #1;
    check({tag, ":en"},     En, 0);
    check({tag, ":busy"},   Busy, 0);
    check({tag, ":ready"},  ibus.InstrReady, 0);
    check({tag, ":flagsq"}, FlagsQ, 0);
    check_fields(tag, '0);
    step();
    Rst = 1'b1;
    step();
    check({tag, ":busy_rel"},  Busy, 0);
    check({tag, ":ready_rel"}, ibus.InstrReady, 1);
    check({tag, ":en_rel"},    En, 0);
    last_legal = '0;
  endtask

  initial begin
    logic [15:0] w;
    logic [4:0]  f;
    Rst             = 1'b0;
    ibus.InstrValid = 1'b0;
    ibus.Instr      = '0;
    Flags           = '0;

    // Reset for two cycles, then release.
    step();
    step();
    check("rst:ready_low", ibus.InstrReady, 0);
    check("rst:busy",      Busy, 0);
    check("rst:en",        En, 0);
    check("rst:ill",       IllegalOp, 0);
    check("rst:flagsq",    FlagsQ, 0);
    check_fields("rst", '0);
    Rst = 1'b1;
    #1;
    check("rst:ready_rel", ibus.InstrReady, 1);
    check("rst:busy_rel",  Busy, 0);
    step();

    // Directed table; illegal rows expect the previous legal fields held.
    vq.push_back('{16'h53FE, 5'h11, mk(0,  3,  0, 5'h05, 16'hFFFE, 1, 1)});
    vq.push_back('{16'h0152, 5'h0A, mk(0,  1,  2, 5'h05, 16'h0000, 0, 1)});
    vq.push_back('{16'hB4FF, 5'h15, mk(0,  4,  0, 5'h0B, 16'hFFFF, 1, 0)});
    vq.push_back('{16'hF2AB, 5'h03, mk(0,  2,  0, 5'h0D, 16'hAB00, 1, 1)});
    vq.push_back('{16'h12F0, 5'h1C, mk(0,  2,  0, 5'h01, 16'h00F0, 1, 1)});
    vq.push_back('{16'h4000, 5'h07, mk(1,  2,  0, 5'h01, 16'h00F0, 1, 0)});
    vq.push_back('{16'h00F3, 5'h07, mk(1,  2,  0, 5'h01, 16'h00F0, 1, 0)});
    vq.push_back('{16'h0F00, 5'h07, mk(1,  2,  0, 5'h01, 16'h00F0, 1, 0)});
    vq.push_back('{16'h0D93, 5'h19, mk(0, 13,  3, 5'h09, 16'h0000, 0, 1)});
    vq.push_back('{16'h9780, 5'h0E, mk(0,  7,  0, 5'h09, 16'hFF80, 1, 1)});
    vq.push_back('{16'hD57F, 5'h12, mk(0,  5,  0, 5'h0D, 16'h007F, 1, 1)});
    vq.push_back('{16'h3A80, 5'h1F, mk(0, 10,  0, 5'h03, 16'h0080, 1, 1)});
    vq.push_back('{16'h0E3C, 5'h05, mk(0, 14, 12, 5'h03, 16'h0000, 0, 1)});
    vq.push_back('{16'h6123, 5'h09, mk(1, 14, 12, 5'h03, 16'h0000, 0, 0)});
    for (int i = 0; i < vq.size(); i++)
      run_instr(vq[i].instr, vq[i].flags, vq[i].e, $sformatf("vec%0d", i));

    // Reset asserted mid-operation.
    reset_mid(2, "rst_exec");
    reset_mid(3, "rst_wb");

    // Randomized words against the reference model.
    for (int i = 0; i < 150; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'h0;
      f = 5'($urandom);
      run_instr(w, f, ref_model(w), $sformatf("rand%0d", i));
    end

`ifdef INSTR_SKID_EN
    // Back-to-back: second word lands in the skid while the first is busy.
    ibus.InstrValid = 1'b1;
    ibus.Instr      = 16'h0152;
    step();                                   // DECODE #1
    check("skid:ready_dec", ibus.InstrReady, 1);
    ibus.Instr = 16'h53FE;
    step();                                   // EXEC #1, skid full
    ibus.InstrValid = 1'b0;
    check("skid:ready_full", ibus.InstrReady, 0);
    check("skid:en_exec1",   En, 0);
    step();                                   // WB #1
    check("skid:en_wb1",    En, 1);
    check("skid:rdest1",    RdestRegLoc, 1);
    step();                                   // DECODE #2
    check("skid:en_dec2",   En, 0);
    check("skid:busy_dec2", Busy, 1);
    check("skid:rdest2",    RdestRegLoc, 3);
    check("skid:imm2",      Imm, 16'hFFFE);
    check("skid:ready_emp", ibus.InstrReady, 1);
    step();                                   // EXEC #2
    check("skid:en_exec2",  En, 0);
    step();                                   // WB #2
    check("skid:en_wb2",    En, 1);
    step();
    check("skid:en_end",    En, 0);
    check("skid:busy_end",  Busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
